// File: rtl/sipo_deser4_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : sipo_deser4_pkg
//  Brief   : Shared state encodings, default width and counter-width helper
//            for the sipo_deser4 deserializer.
//  Rev     : 1.0  initial release
// ============================================================================
package sipo_deser4_pkg;

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_COLLECT = 1'b1;

    localparam int DEFAULT_WIDTH = 4;

    // Width needed to hold 0..width, so the count field matches the bit_cnt port.
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage : sipo_deser4_pkg
`default_nettype wire

// File: rtl/sipo_deser4_bit_cnt.sv
`default_nettype none
// ============================================================================
//  Module  : deser_bit_cnt
//  Brief   : Mod-WIDTH bit counter with enable, sync clear and terminal flag.
//  Rev     : 1.0  initial release
// ============================================================================
module deser_bit_cnt
    import sipo_deser4_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_en,
    input  logic                      i_clr,
    output logic [cnt_w(WIDTH)-1:0]   o_cnt,
    output logic                      o_tc
);

    localparam int                c_CNT_W = cnt_w(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

    logic [c_CNT_W-1:0] r_cnt;

    assign o_tc  = (r_cnt == c_LAST);
    assign o_cnt = r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= o_tc ? '0 : r_cnt + 1'b1;
        end
    end

endmodule : deser_bit_cnt
`default_nettype wire

// File: rtl/sipo_deser4.sv
`default_nettype none
// ============================================================================
//  Module  : sipo_deser4
//  Brief   : Serial-in/parallel-out deserializer with a valid/ready output
//            holding register and sticky overrun flag.
//  Rev     : 1.0  initial release
// ============================================================================
module sipo_deser4
    import sipo_deser4_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst_n,
    input  logic                      clr,
    input  logic                      ser_in,
    input  logic                      ser_en,
    input  logic                      par_rdy,
    output logic [WIDTH-1:0]          par_out,
    output logic                      par_vld,
    output logic [cnt_w(WIDTH)-1:0]   bit_cnt,
    output logic                      busy,
    output logic                      overrun
);

    logic [WIDTH-1:0] r_sreg;
    logic [WIDTH-1:0] r_par_out;
    logic             r_par_vld;
    logic             r_overrun;
    logic [0:0]       r_state;

    logic [WIDTH-1:0] w_word;
    logic             w_tc;
    logic             w_complete;
    logic             w_slot_free;
    logic             w_take;

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_word = {r_sreg[WIDTH-2:0], ser_in};
        end else begin : g_lsb_first
            assign w_word = {ser_in, r_sreg[WIDTH-1:1]};
        end
    endgenerate

    deser_bit_cnt #(
        .WIDTH (WIDTH)
    ) u_bit_cnt (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .i_en  (ser_en),
        .i_clr (clr),
        .o_cnt (bit_cnt),
        .o_tc  (w_tc)
    );

    assign w_complete  = ser_en & w_tc;
    assign w_take      = r_par_vld & par_rdy;
    // A word leaving on this edge frees the slot for one arriving on the same edge.
    assign w_slot_free = ~r_par_vld | par_rdy;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= ST_IDLE;
        end else if (clr) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:    if (ser_en && !w_tc) r_state <= ST_COLLECT;
                ST_COLLECT: if (w_complete)      r_state <= ST_IDLE;
                default:                         r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_sreg    <= '0;
            r_par_out <= '0;
            r_par_vld <= 1'b0;
            r_overrun <= 1'b0;
        end else if (clr) begin
            r_sreg    <= '0;
            r_par_vld <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (ser_en) begin
                r_sreg <= w_word;
            end
            if (w_complete) begin
                if (w_slot_free) begin
                    r_par_out <= w_word;
                    r_par_vld <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (w_take) begin
                r_par_vld <= 1'b0;
            end
        end
    end

    assign par_out = r_par_out;
    assign par_vld = r_par_vld;
    assign overrun = r_overrun;
    assign busy    = (r_state == ST_COLLECT);

endmodule : sipo_deser4
`default_nettype wire

// File: tb/tb_sipo_deser4.sv
`default_nettype none
// ============================================================================
//  Module  : tb_sipo_deser4
//  Brief   : Directed bench driving an MSB-first and an LSB-first instance
//            from one shared serial stream.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_sipo_deser4;

    logic       clk;
    logic       rst_n;
    logic       clr;
    logic       ser_in;
    logic       ser_en;
    logic       par_rdy;

    logic [3:0] m_out, l_out;
    logic       m_vld, l_vld;
    logic [2:0] m_cnt, l_cnt;
    logic       m_busy, l_busy;
    logic       m_ovr, l_ovr;

    int n_tests = 0;
    int n_fail  = 0;

    sipo_deser4 #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
        .sys_clk (clk),   .sys_rst_n (rst_n), .clr (clr),
        .ser_in  (ser_in), .ser_en (ser_en),  .par_rdy (par_rdy),
        .par_out (m_out), .par_vld (m_vld),   .bit_cnt (m_cnt),
        .busy    (m_busy), .overrun (m_ovr)
    );

    sipo_deser4 #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
        .sys_clk (clk),   .sys_rst_n (rst_n), .clr (clr),
        .ser_in  (ser_in), .ser_en (ser_en),  .par_rdy (par_rdy),
        .par_out (l_out), .par_vld (l_vld),   .bit_cnt (l_cnt),
        .busy    (l_busy), .overrun (l_ovr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        ser_in = b;
        ser_en = 1'b1;
        @(negedge clk);
        ser_en = 1'b0;
    endtask

    // Bits go out w[3] first, so the MSB-first instance reassembles w.
    task automatic send_word(input logic [3:0] w);
        for (int i = 3; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic idle_state(input string tag);
        chk({tag, " m_cnt"},  {5'd0, m_cnt}, 8'd0);
        chk({tag, " m_busy"}, {7'd0, m_busy}, 8'd0);
        chk({tag, " m_vld"},  {7'd0, m_vld}, 8'd0);
        chk({tag, " m_ovr"},  {7'd0, m_ovr}, 8'd0);
        chk({tag, " l_cnt"},  {5'd0, l_cnt}, 8'd0);
        chk({tag, " l_vld"},  {7'd0, l_vld}, 8'd0);
    endtask

    initial begin
        rst_n   = 1'b0;
        clr     = 1'b0;
        ser_in  = 1'b0;
        ser_en  = 1'b0;
        par_rdy = 1'b1;

        #15;
        idle_state("reset");
        chk("reset m_out", {4'd0, m_out}, 8'h00);
        #5 rst_n = 1'b1;
        #1 @(negedge clk);

        // 1: MSB-first 1,0,1,1 -> B; LSB-first sees the same stream as D
        send_bit(1'b1);
        send_bit(1'b0);
        chk("t1 cnt2", {5'd0, m_cnt}, 8'd2);
        chk("t1 busy", {7'd0, m_busy}, 8'd1);
        send_bit(1'b1);
        chk("t1 no early vld", {7'd0, m_vld}, 8'd0);
        send_bit(1'b1);
        chk("t1 vld", {7'd0, m_vld}, 8'd1);
        chk("t1 m_out", {4'd0, m_out}, 8'h0B);
        chk("t1 l_out", {4'd0, l_out}, 8'h0D);
        chk("t1 cnt wrap", {5'd0, m_cnt}, 8'd0);
        chk("t1 busy end", {7'd0, m_busy}, 8'd0);
        @(negedge clk);
        chk("t1 vld one cycle", {7'd0, m_vld}, 8'd0);

        // 2: same stream with 3-cycle gaps
        send_bit(1'b1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t2 gap busy", {7'd0, m_busy}, 8'd1);
            chk("t2 gap cnt", {5'd0, m_cnt}, 8'd1);
        end
        send_bit(1'b0);
        repeat (3) @(negedge clk);
        chk("t2 gap busy b2", {7'd0, l_busy}, 8'd1);
        send_bit(1'b1);
        repeat (3) @(negedge clk);
        chk("t2 gap cnt b3", {5'd0, l_cnt}, 8'd3);
        chk("t2 gap no vld", {7'd0, l_vld}, 8'd0);
        send_bit(1'b1);
        chk("t2 vld", {7'd0, l_vld}, 8'd1);
        chk("t2 l_out", {4'd0, l_out}, 8'h0D);
        chk("t2 m_out", {4'd0, m_out}, 8'h0B);
        @(negedge clk);

        // 3: stalled output, second word overruns
        par_rdy = 1'b0;
        send_word(4'h3);
        chk("t3 vld", {7'd0, m_vld}, 8'd1);
        chk("t3 m_out", {4'd0, m_out}, 8'h03);
        chk("t3 no ovr yet", {7'd0, m_ovr}, 8'd0);
        send_word(4'h8);
        chk("t3 hold m_out", {4'd0, m_out}, 8'h03);
        chk("t3 hold l_out", {4'd0, l_out}, 8'h0C);
        chk("t3 hold vld", {7'd0, m_vld}, 8'd1);
        chk("t3 m_ovr", {7'd0, m_ovr}, 8'd1);
        chk("t3 l_ovr", {7'd0, l_ovr}, 8'd1);
        par_rdy = 1'b1;
        @(negedge clk);
        chk("t3 consumed", {7'd0, m_vld}, 8'd0);
        chk("t3 ovr sticky", {7'd0, m_ovr}, 8'd1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("t3 clr ovr", {7'd0, m_ovr}, 8'd0);

        // 4: transfer and next completion on the same edge -> no bubble
        par_rdy = 1'b0;
        send_word(4'h1);
        chk("t4 w1", {4'd0, m_out}, 8'h01);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        chk("t4 w1 held", {4'd0, m_out}, 8'h01);
        chk("t4 vld held", {7'd0, m_vld}, 8'd1);
        par_rdy = 1'b1;
        send_bit(1'b0);
        chk("t4 vld stays", {7'd0, m_vld}, 8'd1);
        chk("t4 w2 m_out", {4'd0, m_out}, 8'h0C);
        chk("t4 w2 l_out", {4'd0, l_out}, 8'h03);
        chk("t4 no ovr", {7'd0, m_ovr}, 8'd0);
        @(negedge clk);
        chk("t4 drained", {7'd0, m_vld}, 8'd0);

        // 5a: clr mid-word (with ser_en high) clears vld/overrun/count
        par_rdy = 1'b0;
        send_word(4'h5);
        send_word(4'hA);
        send_bit(1'b1);
        send_bit(1'b1);
        chk("t5 pre cnt", {5'd0, m_cnt}, 8'd2);
        chk("t5 pre ovr", {7'd0, m_ovr}, 8'd1);
        clr    = 1'b1;
        ser_en = 1'b1;
        ser_in = 1'b1;
        @(negedge clk);
        clr    = 1'b0;
        ser_en = 1'b0;
        idle_state("t5 clr");
        chk("t5 clr keeps out", {4'd0, m_out}, 8'h05);
        par_rdy = 1'b1;
        @(negedge clk);
        chk("t5 rdy ignored", {7'd0, m_vld}, 8'd0);
        send_word(4'h6);
        chk("t5 clr m_out", {4'd0, m_out}, 8'h06);
        chk("t5 clr l_out", {4'd0, l_out}, 8'h06);
        chk("t5 clr vld", {7'd0, m_vld}, 8'd1);
        @(negedge clk);

        // 5b: asynchronous reset mid-cycle, mid-word
        send_bit(1'b1);
        send_bit(1'b0);
        #2 rst_n = 1'b0;
        #1;
        idle_state("t5 arst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_word(4'h6);
        chk("t5 arst m_out", {4'd0, m_out}, 8'h06);
        chk("t5 arst vld", {7'd0, m_vld}, 8'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_sipo_deser4
`default_nettype wire
